sram_host_ctrl: RTL and testbench

//  Upstream command stage for sram_top. Accepts parallel read/write commands over a valid/ready

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_ser_tx.sv | 78 +++++++
 rtl/sram_host_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_host_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared defaults and controller state encoding for the SRAM host-side command stage.
package sram_pkg;

  localparam int unsigned ROWS_DEF         = 16;
  localparam int unsigned COLS_DEF         = 8;
  localparam int unsigned SHIFT_CYCLES_DEF = 2;
  localparam int unsigned RD_TIMEOUT_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    WRITE,
    RDREQ,
    WAIT,
    RESP
  } ctrl_state_e;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_ser_tx.sv
// MSB-first word serialiser: each bit is held on serial_out for SHIFT_CYCLES clocks with shift=1.
// done is high during the final held cycle of bit 0.
module sram_ser_tx
  import sram_pkg::*;
#(
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned SHIFT_CYCLES = SHIFT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [COLS-1:0] word,
  output logic            serial_out,
  output logic            shift,
  output logic            done
);

  localparam int unsigned BW = clog2_min1(COLS);
  localparam int unsigned HW = clog2_min1(SHIFT_CYCLES);

  logic [COLS-1:0] word_q, word_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            serial_q, serial_d;
  logic            shift_q, shift_d;
  logic            last_hold, last_bit;

  assign last_hold  = (hold_q == HW'(SHIFT_CYCLES - 1));
  assign last_bit   = (bit_q == '0);
  assign done       = shift_q && last_hold && last_bit;
  assign serial_out = serial_q;
  assign shift      = shift_q;

  always_comb begin
    word_d   = word_q;
    bit_d    = bit_q;
    hold_d   = hold_q;
    serial_d = serial_q;
    shift_d  = shift_q;
    if (load) begin
      word_d   = word;
      bit_d    = BW'(COLS - 1);
      hold_d   = '0;
      serial_d = word[COLS-1];
      shift_d  = 1'b1;
    end else if (shift_q) begin
      if (!last_hold) begin
        hold_d = hold_q + 1'b1;
      end else if (last_bit) begin
        // Stop at bit 0; the line returns low rather than wrapping.
        hold_d   = '0;
        serial_d = 1'b0;
        shift_d  = 1'b0;
      end else begin
        hold_d   = '0;
        bit_d    = bit_q - 1'b1;
        serial_d = word_q[bit_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      bit_q    <= '0;
      hold_q   <= '0;
      serial_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      word_q   <= word_d;
      bit_q    <= bit_d;
      hold_q   <= hold_d;
      serial_q <= serial_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/sram_host_ctrl.sv
// Host command stage for sram_top: serialises writes, issues read strobes, returns one response
// per command. Optional read timeout is enabled by defining SRAM_RD_TIMEOUT_EN.
module sram_host_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ROWS         = ROWS_DEF,
  parameter int unsigned COLS         = COLS_DEF,
  parameter int unsigned SHIFT_CYCLES = SHIFT_CYCLES_DEF,
  parameter int unsigned RD_TIMEOUT   = RD_TIMEOUT_DEF,
  localparam int unsigned AW          = clog2_min1(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [COLS-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_err,
  output logic            sram_serial_in,
  output logic            sram_shift,
  output logic            sram_w_en,
  output logic            sram_r_en,
  output logic [AW-1:0]   sram_addr,
  input  logic            sram_data_valid,
  input  logic [COLS-1:0] sram_data_out
);

  ctrl_state_e     state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [COLS-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            w_en_q, w_en_d;
  logic            r_en_q, r_en_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            tx_load, tx_done;
  logic            rd_timeout;

  sram_ser_tx #(
    .COLS         (COLS),
    .SHIFT_CYCLES (SHIFT_CYCLES)
  ) u_ser_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (tx_load),
    .word       (cmd_wdata),
    .serial_out (sram_serial_in),
    .shift      (sram_shift),
    .done       (tx_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    tx_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            tx_load = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = RDREQ;
          end
        end
      end
      SHIFT: if (tx_done) state_d = GAP;
      GAP:   state_d = WRITE;
      WRITE: begin
        rsp_data_d = '0;
        state_d    = RESP;
      end
      RDREQ: state_d = WAIT;
      WAIT: begin
        if (sram_data_valid) begin
          rsp_data_d = sram_data_out;
          state_d    = RESP;
        end else if (rd_timeout) begin
          rsp_data_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_data_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they leave a flop aligned with the state.
    rsp_valid_d = (state_d == RESP);
    w_en_d      = (state_d == WRITE);
    r_en_d      = (state_d == RDREQ);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      w_en_q      <= 1'b0;
      r_en_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      w_en_q      <= w_en_d;
      r_en_q      <= r_en_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef SRAM_RD_TIMEOUT_EN
  localparam int unsigned TW = clog2_min1(RD_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rsp_err_q, rsp_err_d;

  assign rd_timeout = (state_q == WAIT) && !sram_data_valid &&
                      (to_cnt_q == TW'(RD_TIMEOUT - 1));

  always_comb begin
    to_cnt_d  = '0;
    rsp_err_d = rsp_err_q;
    if (state_q == WAIT) to_cnt_d = to_cnt_q + 1'b1;
    if (state_q != RESP && state_d == RESP) begin
      rsp_err_d = rd_timeout;
    end else if (state_d == IDLE) begin
      rsp_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rd_timeout = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sram_w_en = w_en_q;
  assign sram_r_en = r_en_q;
  assign sram_addr = addr_q;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Directed bench for sram_host_ctrl with a small behavioural sram_top stand-in.
module tb_sram_host_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       sram_serial_in, sram_shift, sram_w_en, sram_r_en;
  logic [3:0] sram_addr;
  logic       sram_data_valid;
  logic [7:0] sram_data_out;

  int total = 0;
  int bad   = 0;

  // SRAM stand-in: samples every shift cycle, so bit i of the word lands in sr[2*i].
  logic [15:0] sr;
  logic [7:0]  mem [16];
  logic        st1, dv_m, model_en = 1'b1, inj_dv = 1'b0;
  logic [7:0]  dout_m, inj_data = '0;

  assign sram_data_valid = dv_m | inj_dv;
  assign sram_data_out   = inj_dv ? inj_data : dout_m;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      sr     <= '0;
      st1    <= 1'b0;
      dv_m   <= 1'b0;
      dout_m <= '0;
    end else begin
      if (sram_shift) sr <= {sr[14:0], sram_serial_in};
      if (sram_w_en)
        mem[sram_addr] <= {sr[14], sr[12], sr[10], sr[8], sr[6], sr[4], sr[2], sr[0]};
      st1  <= sram_r_en & model_en;
      dv_m <= st1;
      if (st1) dout_m <= mem[sram_addr];
    end
  end

  sram_host_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .sram_serial_in  (sram_serial_in),
    .sram_shift      (sram_shift),
    .sram_w_en       (sram_w_en),
    .sram_r_en       (sram_r_en),
    .sram_addr       (sram_addr),
    .sram_data_valid (sram_data_valid),
    .sram_data_out   (sram_data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for exactly one edge; on return the bench observes cycle 1.
  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid, rsp_err} !== 6'b0 ||
        sram_addr !== 4'h0 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b addr=%h data=%h exp=0",
               {sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid, rsp_err},
               sram_addr, rsp_data);
    end
    rst = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write();
    logic [7:0] wd;
    logic       eb;
    wd = 8'b10011101;
    rsp_ready = 1'b1;
    issue(1'b1, 4'd1, wd);
    for (int c = 1; c <= 20; c++) begin
      if (c <= 16) begin
        eb = wd[7 - (c - 1) / 2];
        total++;
        if ({sram_shift, sram_serial_in, sram_w_en, sram_r_en} !== {1'b1, eb, 2'b00}) begin
          bad++;
          $display("FAIL wr_shift c=%0d got=%b exp=%b", c,
                   {sram_shift, sram_serial_in, sram_w_en, sram_r_en}, {1'b1, eb, 2'b00});
        end
      end else if (c == 17) begin
        total++;
        if ({sram_shift, sram_w_en, rsp_valid} !== 3'b000) begin
          bad++;
          $display("FAIL wr_gap got=%b exp=000", {sram_shift, sram_w_en, rsp_valid});
        end
      end else if (c == 18) begin
        total++;
        if ({sram_shift, sram_w_en, rsp_valid} !== 3'b010) begin
          bad++;
          $display("FAIL wr_wen got=%b exp=010", {sram_shift, sram_w_en, rsp_valid});
        end
      end else if (c == 19) begin
        total++;
        if ({sram_w_en, rsp_valid, rsp_err} !== 3'b010 || rsp_data !== 8'h00) begin
          bad++;
          $display("FAIL wr_rsp got=%b data=%h exp=010 data=00",
                   {sram_w_en, rsp_valid, rsp_err}, rsp_data);
        end
      end else begin
        total++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
          bad++;
          $display("FAIL wr_done got=%b exp=01", {rsp_valid, cmd_ready});
        end
      end
      if (c == 1) begin
        total++;
        if (sram_addr !== 4'd1 || cmd_ready !== 1'b0) begin
          bad++;
          $display("FAIL wr_addr got addr=%h rdy=%b exp addr=1 rdy=0", sram_addr, cmd_ready);
        end
      end
      if (c < 20) tick();
    end
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    issue(1'b0, 4'd1, 8'h00);
    total++;
    if ({sram_r_en, sram_shift, sram_w_en} !== 3'b100 || sram_addr !== 4'd1) begin
      bad++;
      $display("FAIL rd_ren got=%b addr=%h exp=100 addr=1",
               {sram_r_en, sram_shift, sram_w_en}, sram_addr);
    end
    tick();
    total++;
    if (sram_r_en !== 1'b0) begin
      bad++;
      $display("FAIL rd_ren_pulse got=%b exp=0", sram_r_en);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_early got=%b exp=0", rsp_valid);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_data !== 8'h9D) begin
      bad++;
      $display("FAIL rd_rsp got=%b data=%h exp=10 data=9d", {rsp_valid, rsp_err}, rsp_data);
    end
    tick();
  endtask

  task automatic test_dv_ignore();
    model_en  = 1'b0;
    rsp_ready = 1'b1;
    inj_dv    = 1'b1;
    inj_data  = 8'h55;
    tick();
    inj_dv = 1'b0;
    tick();
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL dv_idle got=%b exp=01", {rsp_valid, cmd_ready});
    end
    // data_valid held high through the RDREQ cycle must not complete the read.
    inj_dv = 1'b1;
    issue(1'b0, 4'd7, 8'h00);
    tick();
    inj_dv = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL dv_rdreq got=%b exp=0", rsp_valid);
    end
    tick();
    inj_dv   = 1'b1;
    inj_data = 8'hA5;
    tick();
    inj_dv = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin
      bad++;
      $display("FAIL dv_wait got=%b data=%h exp=1 data=a5", rsp_valid, rsp_data);
    end
    tick();
    model_en = 1'b1;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b0, 4'd1, 8'h00);
    tick();
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd5;
    for (int c = 4; c <= 8; c++) begin
      total++;
      if ({rsp_valid, cmd_ready, sram_r_en} !== 3'b100 || rsp_data !== 8'h9D) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%b data=%h exp=100 data=9d", c,
                 {rsp_valid, cmd_ready, sram_r_en}, rsp_data);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release got=%b exp=01", {rsp_valid, cmd_ready});
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({sram_r_en, cmd_ready} !== 2'b10 || sram_addr !== 4'd5) begin
      bad++;
      $display("FAIL bp_next got=%b addr=%h exp=10 addr=5", {sram_r_en, cmd_ready}, sram_addr);
    end
    tick();
    tick();
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL bp_next_rsp got=%b data=%h exp=1 data=00", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    rsp_ready = 1'b1;
    issue(1'b1, 4'd2, 8'hAA);
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid, rsp_err} !== 6'b0 ||
        sram_addr !== 4'h0 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_outputs got=%b addr=%h data=%h exp=0",
               {sram_shift, sram_serial_in, sram_w_en, sram_r_en, rsp_valid, rsp_err},
               sram_addr, rsp_data);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_ready got=%b exp=1", cmd_ready);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (sram_w_en === 1'b1 || rsp_valid === 1'b1 || sram_shift === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rstmid_quiet got=%0d active cycles exp=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    issue(1'b1, 4'd3, 8'hFF);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd3;
    for (int c = 1; c < 19; c++) tick();
    total++;
    if ({rsp_valid, cmd_ready} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_wrsp got=%b exp=10", {rsp_valid, cmd_ready});
    end
    tick();
    total++;
    if ({rsp_valid, cmd_ready, sram_r_en} !== 3'b010) begin
      bad++;
      $display("FAIL b2b_gap got=%b exp=010", {rsp_valid, cmd_ready, sram_r_en});
    end
    tick();
    cmd_valid = 1'b0;
    total++;
    if (sram_r_en !== 1'b1 || sram_addr !== 4'd3) begin
      bad++;
      $display("FAIL b2b_ren got=%b addr=%h exp=1 addr=3", sram_r_en, sram_addr);
    end
    tick();
    tick();
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL b2b_rdata got=%b data=%h err=%b exp=1 data=ff err=0",
               rsp_valid, rsp_data, rsp_err);
    end
    tick();
  endtask

`ifdef SRAM_RD_TIMEOUT_EN
  task automatic test_timeout();
    model_en  = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 4'd4, 8'h00);
    total++;
    if (sram_r_en !== 1'b1) begin
      bad++;
      $display("FAIL to_ren got=%b exp=1", sram_r_en);
    end
    for (int c = 1; c < 17; c++) tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_early got=%b exp=0", rsp_valid);
    end
    tick();
    total++;
    if ({rsp_valid, rsp_err} !== 2'b11 || rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL to_rsp got=%b data=%h exp=11 data=00", {rsp_valid, rsp_err}, rsp_data);
    end
    tick();
    model_en = 1'b1;
  endtask
`else
  task automatic test_wait_forever();
    int seen;
    model_en  = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 4'd4, 8'h00);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL wait_forever got=%0d rsp cycles exp=0", seen);
    end
    inj_dv   = 1'b1;
    inj_data = 8'h5A;
    tick();
    inj_dv = 1'b0;
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_data !== 8'h5A) begin
      bad++;
      $display("FAIL wait_late_rsp got=%b data=%h exp=10 data=5a", {rsp_valid, rsp_err}, rsp_data);
    end
    tick();
    model_en = 1'b1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_dv_ignore();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SRAM_RD_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
